// File: rtl/seg_pkg.sv
// Shared display constants for the 7-segment scan drivers: blank code,
// hex-to-segment table (active-low, bit 7 unused) and scan phase enum.
package seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Entry n is the active-low pattern for hex digit n; bit 7 is overwritten by dp.
    localparam logic [15:0][7:0] SEG_HEX_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } seg_state_t;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble + decimal-point to active-low segment decoder.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_dp,
    output logic [7:0] o_seg
);

    // Table lookup with the dp bit replacing the table's bit 7.
    always_comb begin
        o_seg = {~i_dp, SEG_HEX_TABLE[i_nibble][6:0]};
    end

endmodule

// File: rtl/seg_scan8.sv
// Double-buffered 8-digit multiplexed scan driver for a common-anode display.
// Optional build macro SEG_SCAN8_LEAD_ZERO_BLANK_EN blanks leading zero digits.
module seg_scan8
    import seg_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] data,
    input  logic [7:0]  dp_in,
    output logic [7:0]  seg,
    output logic [7:0]  dig,
    output logic        frame_done
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [31:0]  r_active_word;
    logic [7:0]   r_active_dp;
    logic [31:0]  r_shadow_word;
    logic [7:0]   r_shadow_dp;
    logic         r_pending;
    logic [CW-1:0] r_cnt;
    logic [2:0]   r_idx;
    seg_state_t   r_state;

    logic          w_wrap;
    logic          w_boundary;
    logic [CW-1:0] w_cnt_nxt;
    logic [2:0]    w_idx_nxt;
    seg_state_t    w_state_nxt;
    logic [3:0]    w_nibble;
    logic          w_dp;
    logic [7:0]    w_dec_seg;
    logic          w_digit_blank;

    // Next slot position and phase; outputs are registered from these.
    always_comb begin
        w_wrap     = (r_cnt == CW'(SCAN_DIV - 1));
        w_boundary = w_wrap && (r_idx == 3'd7);
        if (w_wrap) begin
            w_cnt_nxt   = '0;
            w_idx_nxt   = r_idx + 3'd1;
            w_state_nxt = ST_BLANK;
        end else begin
            w_cnt_nxt   = r_cnt + CW'(1);
            w_idx_nxt   = r_idx;
            w_state_nxt = (r_cnt == CW'(BLANK_CYC - 1)) ? ST_SHOW : r_state;
        end
        w_nibble = r_active_word[{w_idx_nxt, 2'b00} +: 4];
        w_dp     = r_active_dp[w_idx_nxt];
    end

    seg_hex_decode u_decode (
        .i_nibble (w_nibble),
        .i_dp     (w_dp),
        .o_seg    (w_dec_seg)
    );

`ifdef SEG_SCAN8_LEAD_ZERO_BLANK_EN
    logic [7:0] w_lz_blank;
    logic       w_lz_run;

    // A digit is blank while it and everything above it is zero with no dp lit.
    always_comb begin
        w_lz_run   = 1'b1;
        w_lz_blank = 8'h00;
        for (int i = 7; i >= 1; i--) begin
            w_lz_run      = w_lz_run & (r_active_word[4*i +: 4] == 4'h0) & ~r_active_dp[i];
            w_lz_blank[i] = w_lz_run;
        end
    end

    assign w_digit_blank = w_lz_blank[w_idx_nxt];
`else
    assign w_digit_blank = 1'b0;
`endif

    // Scan FSM, frame buffers and registered display outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_active_word <= 32'h0000_0000;
            r_active_dp   <= 8'h00;
            r_shadow_word <= 32'h0000_0000;
            r_shadow_dp   <= 8'h00;
            r_pending     <= 1'b0;
            r_cnt         <= '0;
            r_idx         <= 3'd0;
            r_state       <= ST_BLANK;
            seg           <= SEG_BLANK;
            dig           <= 8'hFF;
            frame_done    <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_idx      <= w_idx_nxt;
            r_state    <= w_state_nxt;
            frame_done <= w_boundary;

            if (load) begin
                r_shadow_word <= data;
                r_shadow_dp   <= dp_in;
            end else begin
                r_shadow_word <= r_shadow_word;
                r_shadow_dp   <= r_shadow_dp;
            end

            // A load on the boundary itself beats any older pending value.
            if (w_boundary) begin
                if (load) begin
                    r_active_word <= data;
                    r_active_dp   <= dp_in;
                end else if (r_pending) begin
                    r_active_word <= r_shadow_word;
                    r_active_dp   <= r_shadow_dp;
                end else begin
                    r_active_word <= r_active_word;
                    r_active_dp   <= r_active_dp;
                end
                r_pending <= 1'b0;
            end else begin
                r_pending <= r_pending | load;
            end

            case (w_state_nxt)
                ST_SHOW: begin
                    dig <= ~(8'd1 << w_idx_nxt);
                    seg <= w_digit_blank ? SEG_BLANK : w_dec_seg;
                end
                ST_BLANK: begin
                    dig <= 8'hFF;
                    seg <= SEG_BLANK;
                end
                default: begin
                    dig <= 8'hFF;
                    seg <= SEG_BLANK;
                end
            endcase
        end
    end

endmodule

// File: doc/seg_scan8.md
Name: seg_scan8

Overview:
- Multiplexed 8-digit scan driver for the board's common-anode 7-segment display.
- Sits upstream of the display pins. It consumes a 32-bit hex word (8 nibbles) plus 8 decimal-point flags from the application logic.
- Drives one digit at a time, with a blanking gap between digits to stop ghosting.
- Double-buffers the input so a new value only takes effect at a frame boundary, which prevents tearing.

Parameters:
- SCAN_DIV, 50000: clock cycles per digit slot (blank phase + show phase). Must be >= BLANK_CYC+1.
- BLANK_CYC, 500: cycles at the start of each slot with all digits off. Must be >= 1.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- load  in  1  single-cycle strobe; captures data and dp_in.
- data  in  32  nibble i = data[4i+3:4i] goes to digit i; digit 0 is rightmost.
- dp_in  in  8  dp_in[i]=1 lights the decimal point of digit i.
- seg  out  8  segments, active-low. seg[6:0]=g..a, seg[7]=dp.
- dig  out  8  digit enables, active-low, one-hot-low while showing.
- frame_done  out  1  one-cycle pulse when digit 7's slot ends.

Behaviour:
- Registers:
  - active word/dp (32+8 bits).
  - shadow word/dp (32+8 bits) plus a pending flag.
  - slot counter cnt, 0..SCAN_DIV-1.
  - digit index idx, 0..7.
  - state ∈ {BLANK, SHOW}.
- Reset (async, takes effect immediately):
  - active, shadow = 0; pending = 0; cnt = 0; idx = 0; state = BLANK.
  - Outputs: seg = 8'hFF, dig = 8'hFF, frame_done = 0.
- cnt increments every cycle and wraps SCAN_DIV-1 -> 0.
- Phase sequence within a slot:
  - BLANK for cnt 0..BLANK_CYC-1.
  - SHOW for cnt BLANK_CYC..SCAN_DIV-1.
  - At wrap, idx advances (7 -> 0) and state returns to BLANK.
- Outputs are registered; they change on the edge that enters the phase.
  - BLANK: dig = 8'hFF, seg = 8'hFF.
  - SHOW: dig = ~(1<<idx); seg[6:0] = decode(active nibble idx); seg[7] = ~active_dp[idx].
- Decode table (active-low):
  - 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8
  - 8:80 9:90 A:88 b:83 C:C6 d:A1 E:86 F:8E
  - The table gives seg[6:0]; its bit 7 is replaced by the dp bit.
- load handling:
  - On load: shadow <= {data, dp_in}; pending <= 1.
  - If another load arrives while pending, the last one wins.
- Frame boundary = the cycle where idx==7 and cnt==SCAN_DIV-1. On that cycle:
  - frame_done = 1 (registered, visible the following cycle).
  - If pending: active <= shadow, pending <= 0.
  - If load is also high on the boundary cycle: active <= {data, dp_in} directly, pending <= 0. The new value wins over an older pending one.
- Latency:
  - A load during a frame is first displayed in digit 0's SHOW phase of the next frame.
  - Worst case: 8*SCAN_DIV + BLANK_CYC + 1 cycles.
- No input is required to be stable outside the load cycle. There is no backpressure; load is never refused.

Optional Feature:
- Macro: SEG_SCAN8_LEAD_ZERO_BLANK_EN.
- When defined: during SHOW, digit i shows blank (seg=8'hFF, dig still enabled) if its nibble and every nibble above it are 0 and i != 0.
  - Digit 0 is always shown.
  - A set dp bit forces that digit and all lower digits to be shown.
- When undefined: all 8 digits are always decoded. No extra logic.

Decomposition:
- Package seg_pkg:
  - SEG_BLANK = 8'hFF constant.
  - 16-entry hex-to-segment constant table.
  - state enum {BLANK, SHOW}.
- Sub-module seg_hex_decode: combinational, 4-bit nibble + dp -> 8-bit active-low seg. Reused by other display blocks.

Test Plan (bench uses SCAN_DIV=8, BLANK_CYC=2):
- Reset, then run 1 frame:
  - seg=FF, dig=FF during cycles 0-1 of each slot.
  - Cycles 2-7: seg=C0, dig=FE, FD, … 7F in turn.
  - frame_done pulses once per 64 cycles.
- Load 32'h89ABCDEF, dp_in=8'h01 mid-frame:
  - Current frame is unchanged.
  - Next frame: digit 0 seg=0E (F with dp), digit 1 seg=86, … digit 7 seg=80.
- Two loads in one frame (32'h11111111, then 32'h22222222):
  - Only 22222222 is ever displayed (seg=A4 on all digits).
  - 11111111 never appears.
- Load asserted exactly on the boundary cycle with a different value already pending:
  - The boundary-cycle value is displayed in the next frame.
  - pending = 0 afterwards.
- Assert reset during a SHOW phase of digit 5:
  - seg/dig go to FF in the same cycle, without waiting for a clock edge.
  - After release, scanning restarts at digit 0 BLANK and shows 00000000.
- With SEG_SCAN8_LEAD_ZERO_BLANK_EN, load 32'h00000305, dp_in=0:
  - Digits 7-3 show FF; digits 2,1,0 show B0, C0, 92.
  - Load 0: only digit 0 shows C0.
